// File: rtl/redirect_read_engine_if.sv
// Load, request and response signals of the redirect read engine.
// The engine sits on the slave modport; whoever drives requests and loads uses master.
interface redirect_read_engine_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_start;
  logic                  rd_consume;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_found;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [ADDR_WIDTH:0]   used_count;
  logic                  busy;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_start, rd_consume, resp_ready,
    output rd_ready, resp_valid, resp_found, resp_addr, resp_data, used_count, busy
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_start, rd_consume, resp_ready,
    input  rd_ready, resp_valid, resp_found, resp_addr, resp_data, used_count, busy
  );
endinterface

// File: rtl/redirect_read_engine.sv
// Scans upward (with wrap) from a start address to the first occupied word, returns it and optionally frees it.
// One address per cycle, response k+1 edges after accept for a hit at offset k; response held until resp_ready.
module redirect_read_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  redirect_read_engine_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] checked_q;
  logic                  consume_q;
  logic                  rd_ready_q;
  logic                  resp_valid_q;
  logic                  busy_q;
  logic                  resp_found_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      used_q, used_d;
  logic [ADDR_WIDTH:0]   used_count_q, used_count_d;

  logic hit;
  logic clr;
  logic clr_eff;
  logic set_new;
  logic last;

  assign hit     = (state_q == SCAN) && used_q[ptr_q];
  assign clr     = hit && consume_q;
  assign set_new = bus.wr_en && !used_q[bus.wr_addr];
  // A load to the word being consumed re-occupies it, so the count must not drop.
  assign clr_eff = clr && !(bus.wr_en && (bus.wr_addr == ptr_q));
  assign last    = (checked_q == {ADDR_WIDTH{1'b1}});

  always_comb begin
    used_d = used_q;
    if (clr) used_d[ptr_q] = 1'b0;
    if (bus.wr_en) used_d[bus.wr_addr] = 1'b1;
  end

  always_comb begin
    used_count_d = used_count_q;
    case ({set_new, clr_eff})
      2'b10:   used_count_d = used_count_q + CNT_ONE;
      2'b01:   used_count_d = used_count_q - CNT_ONE;
      default: used_count_d = used_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q       <= '0;
      used_count_q <= '0;
    end else begin
      used_q       <= used_d;
      used_count_q <= used_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      start_q      <= '0;
      checked_q    <= '0;
      consume_q    <= 1'b0;
      rd_ready_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_found_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rd_req) begin
            ptr_q      <= bus.rd_start;
            start_q    <= bus.rd_start;
            consume_q  <= bus.rd_consume;
            checked_q  <= '0;
            rd_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            resp_found_q <= 1'b1;
            resp_addr_q  <= ptr_q;
            resp_data_q  <= mem_q[ptr_q];
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (last) begin
            resp_found_q <= 1'b0;
            resp_addr_q  <= start_q;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            ptr_q     <= ptr_q + ADDR_ONE;
            checked_q <= checked_q + ADDR_ONE;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rd_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          rd_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_ready   = rd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.busy       = busy_q;
  assign bus.resp_found = resp_found_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.used_count = used_count_q;
endmodule

// File: tb/tb_redirect_read_engine.sv
// Scoreboard bench for redirect_read_engine: directed scenarios plus random loads and scans.
module tb_redirect_read_engine;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  redirect_read_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  redirect_read_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          found;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_used [DEPTH];
  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int rr_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic int m_count();
    int n = 0;
    foreach (m_used[i]) if (m_used[i]) n++;
    return n;
  endfunction

  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = ($urandom_range(0, 2) != 0);
        1:       bus.resp_ready = 1'b1;
        default: bus.resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented response cycle against the scoreboard head.
  bit prev_vld = 0;
  bit prev_acc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 0;
      prev_acc = 0;
    end else begin
      if (prev_acc) chk("rd_ready_after_accept", {31'd0, bus.rd_ready}, 32'd1);
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          timeout("unexpected_resp");
        end else begin
          chk("resp_found", {31'd0, bus.resp_found}, {31'd0, sb[0].found});
          chk("resp_addr", {24'd0, bus.resp_addr}, {24'd0, sb[0].addr});
          chk("resp_data", {24'd0, bus.resp_data}, {24'd0, sb[0].data});
          chk("rd_ready_in_resp", {31'd0, bus.rd_ready}, 32'd0);
          if (!prev_vld) chk("resp_latency", cyc - acc_cyc, sb[0].lat);
          if (bus.resp_ready) void'(sb.pop_front());
        end
      end
      prev_acc = bus.resp_valid && bus.resp_ready;
      prev_vld = bus.resp_valid;
    end
  end

  task automatic load(int a, int d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[AW-1:0];
    bus.wr_data = d[DW-1:0];
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    m_mem[a]  = d[DW-1:0];
    m_used[a] = 1;
  endtask

  task automatic do_req(int start, bit consume, bit coll, int cdata);
    exp_t e;
    int   n = 0;
    e.found = 1'b0;
    e.addr  = start[AW-1:0];
    e.data  = '0;
    e.lat   = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      int a;
      a = (start + k) % DEPTH;
      if (m_used[a]) begin
        e.found = 1'b1;
        e.addr  = a[AW-1:0];
        e.data  = m_mem[a];
        e.lat   = k + 1;
        break;
      end
    end
    @(negedge clk);
    while (!bus.rd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rd_ready) begin
      timeout("req_ready_wait");
      return;
    end
    bus.rd_req     = 1'b1;
    bus.rd_start   = start[AW-1:0];
    bus.rd_consume = consume;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    bus.rd_req = 1'b0;
    if (coll) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = start[AW-1:0];
      bus.wr_data = cdata[DW-1:0];
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
    end
    if (consume && e.found) m_used[e.addr] = 0;
    if (coll) begin
      m_mem[start]  = cdata[DW-1:0];
      m_used[start] = 1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((!bus.rd_ready || sb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rd_ready || sb.size() != 0) timeout("idle_wait");
    chk("used_count", {23'd0, bus.used_count}, m_count());
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_used_count", {23'd0, bus.used_count}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
    chk("rst_resp_found", {31'd0, bus.resp_found}, 32'd0);
    chk("rst_resp_addr", {24'd0, bus.resp_addr}, 32'd0);
    chk("rst_resp_data", {24'd0, bus.resp_data}, 32'd0);
    sb.delete();
    foreach (m_used[i]) m_used[i] = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_req     = 1'b0;
    bus.rd_start   = '0;
    bus.rd_consume = 1'b0;
    foreach (m_mem[i]) m_mem[i] = '0;
    do_reset();

    // Hit at the start address, no consume.
    load(30, 99); load(31, 111); load(32, 113); load(33, 200);
    do_req(31, 0, 0, 0);
    wait_idle();

    // Skip forward, consume, then wrap around to the only remaining word.
    do_reset();
    load(30, 100); load(33, 200);
    do_req(31, 1, 0, 0);
    wait_idle();
    do_req(31, 1, 0, 0);
    wait_idle();

    // Full miss on empty memory.
    do_reset();
    do_req(250, 0, 0, 0);
    wait_idle();

    // Response backpressure.
    load(40, 77);
    rr_mode = 2;
    do_req(40, 0, 0, 0);
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) timeout("hold_resp_wait");
    repeat (5) @(negedge clk);
    rr_mode = 1;
    wait_idle();

    // Load collides with consume of the same word.
    do_reset();
    load(35, 120);
    do_req(35, 1, 1, 220);
    wait_idle();
    do_req(35, 0, 0, 0);
    wait_idle();

    // Reset during a long scan aborts it.
    do_reset();
    load(207, 55);
    do_req(7, 1, 0, 0);
    repeat (20) @(posedge clk);
    do_reset();
    do_req(7, 0, 0, 0);
    wait_idle();

    // Random loads and scans with random response backpressure.
    rr_mode = 0;
    for (int it = 0; it < 25; it++) begin
      int nl;
      nl = $urandom_range(0, 4);
      for (int j = 0; j < nl; j++) load($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      do_req($urandom_range(0, DEPTH - 1), $urandom_range(0, 1) != 0, 0, 0);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
